// File: rtl/ans_ht_ltf_stream_buffer.sv
// rtl/ans_ht_ltf_stream_buffer.sv - HT-LTF burst capture buffer with N_LTF replay and P_HTLTF polarity
//
// Kicks the HT-LTF generator, captures its SYM_LEN-sample burst and replays it
// 1, 2 or 4 times as a valid/ready stream. The second symbol is negated.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, n_ltf        field request pulse and symbol count (0:1, 1:2, 2/3:4)
//   gen_letsgo          1-cycle kick to the generator
//   gen_givemeoutput    high while waiting for the generator's first sample
//   gen_sample          generator sample {I[31:16], Q[15:0]}
//   gen_started         generator first-output indication
//   m_tdata/m_tvalid/m_tready/m_tlast   output sample stream
//   busy                high whenever not idle
//   err_timeout         1-cycle pulse when the generator never started
module ans_ht_ltf_stream_buffer #(
   parameter int SYM_LEN = 80,
   parameter int TIMEOUT = 1023
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  n_ltf,
   output logic        gen_letsgo,
   output logic        gen_givemeoutput,
   input  logic [31:0] gen_sample,
   input  logic        gen_started,
   output logic [31:0] m_tdata,
   output logic        m_tvalid,
   input  logic        m_tready,
   output logic        m_tlast,
   output logic        busy,
   output logic        err_timeout
);

   localparam int AW = $clog2(SYM_LEN);
   localparam int CW = $clog2(SYM_LEN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [AW-1:0] LAST_IDX  = AW'(SYM_LEN - 1);
   localparam logic [CW-1:0] FULL_CNT  = CW'(SYM_LEN);
   localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_KICK,
      S_WAIT_GEN,
      S_STREAM
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    last_sym_q, last_sym_d;
   logic [CW-1:0] wr_cnt_q, wr_cnt_d;
   logic [AW-1:0] rd_idx_q, rd_idx_d;
   logic [1:0]    sym_idx_q, sym_idx_d;
   logic [TW-1:0] timer_q, timer_d;

   logic [31:0]   buf_q [0:SYM_LEN-1];
   logic          buf_we;
   logic [AW-1:0] buf_waddr;
   logic [31:0]   buf_wdata;
   logic [31:0]   rd_word;

   // Two's-complement negation that maps -32768 to +32767 instead of wrapping.
   function automatic logic [15:0] sat_neg(input logic [15:0] h);
      if (h == 16'h8000) begin
         return 16'h7FFF;
      end
      return 16'h0000 - h;
   endfunction

   assign rd_word = buf_q[rd_idx_q];

   always_comb begin
      state_d          = state_q;
      last_sym_d       = last_sym_q;
      wr_cnt_d         = wr_cnt_q;
      rd_idx_d         = rd_idx_q;
      sym_idx_d        = sym_idx_q;
      timer_d          = timer_q;
      buf_we           = 1'b0;
      buf_waddr        = AW'(wr_cnt_q);
      buf_wdata        = gen_sample;
      gen_letsgo       = 1'b0;
      gen_givemeoutput = 1'b0;
      err_timeout      = 1'b0;
      m_tvalid         = 1'b0;
      m_tlast          = 1'b0;
      m_tdata          = 32'h0;
      busy             = (state_q != S_IDLE);

      case (state_q)
         S_IDLE: begin
            if (start) begin
               case (n_ltf)
                  2'd0:    last_sym_d = 2'd0;
                  2'd1:    last_sym_d = 2'd1;
                  default: last_sym_d = 2'd3;
               endcase
               wr_cnt_d  = '0;
               rd_idx_d  = '0;
               sym_idx_d = '0;
               timer_d   = '0;
               state_d   = S_KICK;
            end
         end

         S_KICK: begin
            gen_letsgo = 1'b1;
            timer_d    = '0;
            state_d    = S_WAIT_GEN;
         end

         S_WAIT_GEN: begin
            gen_givemeoutput = 1'b1;
            if (gen_started) begin
               buf_we    = 1'b1;
               buf_waddr = '0;
               wr_cnt_d  = CW'(1);
               state_d   = S_STREAM;
            end else if (timer_q == TIMER_MAX) begin
               err_timeout = 1'b1;
               state_d     = S_IDLE;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end

         S_STREAM: begin
            // The generator emits one sample per clock with no handshake, so
            // capture continues blindly until the buffer is full.
            if (wr_cnt_q < FULL_CNT) begin
               buf_we   = 1'b1;
               wr_cnt_d = wr_cnt_q + CW'(1);
            end

            // Once the first symbol has been read out the whole burst is
            // resident, so later symbols never wait on the writer.
            m_tvalid = (sym_idx_q != 2'd0) || (CW'(rd_idx_q) < wr_cnt_q);
            m_tlast  = m_tvalid && (rd_idx_q == LAST_IDX) && (sym_idx_q == last_sym_q);
            if (m_tvalid) begin
               if (sym_idx_q == 2'd1) begin
                  m_tdata = {sat_neg(rd_word[31:16]), sat_neg(rd_word[15:0])};
               end else begin
                  m_tdata = rd_word;
               end
            end

            if (m_tvalid && m_tready) begin
               if (m_tlast) begin
                  state_d = S_IDLE;
               end else if (rd_idx_q == LAST_IDX) begin
                  rd_idx_d  = '0;
                  sym_idx_d = sym_idx_q + 2'd1;
               end else begin
                  rd_idx_d = rd_idx_q + AW'(1);
               end
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         last_sym_q <= '0;
         wr_cnt_q   <= '0;
         rd_idx_q   <= '0;
         sym_idx_q  <= '0;
         timer_q    <= '0;
      end else begin
         state_q    <= state_d;
         last_sym_q <= last_sym_d;
         wr_cnt_q   <= wr_cnt_d;
         rd_idx_q   <= rd_idx_d;
         sym_idx_q  <= sym_idx_d;
         timer_q    <= timer_d;
      end
   end

   // Sample storage needs no reset: a read is only exposed after its write.
   always_ff @(posedge clk) begin
      if (buf_we) begin
         buf_q[buf_waddr] <= buf_wdata;
      end
   end

endmodule

// File: tb/tb_ans_ht_ltf_stream_buffer.sv
// tb/tb_ans_ht_ltf_stream_buffer.sv - self-checking bench for ans_ht_ltf_stream_buffer
module tb_ans_ht_ltf_stream_buffer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  n_ltf;
   logic        gen_letsgo;
   logic        gen_givemeoutput;
   logic [31:0] gen_sample;
   logic        gen_started;
   logic [31:0] m_tdata;
   logic        m_tvalid;
   logic        m_tready;
   logic        m_tlast;
   logic        busy;
   logic        err_timeout;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [31:0] samp [80];
   bit          gen_enable = 1'b1;
   int          gen_delay = 0;
   int          gen_start_cyc = -1;

   logic [31:0] got_data [$];
   bit          got_last [$];
   int          first_valid_cyc;
   int          last_hs_cyc;
   int          stall_err;
   int          idle_gaps;
   bit          col_timeout;

   ans_ht_ltf_stream_buffer dut (
      .clk              (clk),
      .reset            (reset),
      .start            (start),
      .n_ltf            (n_ltf),
      .gen_letsgo       (gen_letsgo),
      .gen_givemeoutput (gen_givemeoutput),
      .gen_sample       (gen_sample),
      .gen_started      (gen_started),
      .m_tdata          (m_tdata),
      .m_tvalid         (m_tvalid),
      .m_tready         (m_tready),
      .m_tlast          (m_tlast),
      .busy             (busy),
      .err_timeout      (err_timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

   // Generator model: after a kick, waits a few cycles, then emits 80 samples
   // back to back; started drops early (recycle phase), then garbage follows.
   initial begin
      gen_started = 1'b0;
      gen_sample  = 32'h0;
      forever begin
         @(negedge clk);
         if (gen_enable && gen_letsgo) begin
            @(negedge clk);
            repeat (gen_delay) @(negedge clk);
            gen_start_cyc = cyc;
            gen_started   = 1'b1;
            gen_sample    = samp[0];
            for (int k = 1; k < 80; k++) begin
               @(negedge clk);
               gen_sample  = samp[k];
               gen_started = (k < 64);
            end
            @(negedge clk);
            gen_started = 1'b0;
            gen_sample  = $urandom;
         end
      end
   end

   function automatic logic [15:0] ref_neg(input logic [15:0] h);
      int v;
      v = -int'($signed(h));
      if (v > 32767) v = 32767;
      return v[15:0];
   endfunction

   // Reference: symbol s of the field is the captured burst, with P_HTLTF
   // row [+1,-1,+1,+1] applied.
   function automatic logic [31:0] expect_word(input int s, input int k);
      logic [31:0] w;
      w = samp[k];
      if (s == 1) return {ref_neg(w[31:16]), ref_neg(w[15:0])};
      return w;
   endfunction

   task automatic fill_random();
      for (int k = 0; k < 80; k++) samp[k] = $urandom;
   endtask

   task automatic do_start(input logic [1:0] n, output logic ls, output logic bz);
      @(negedge clk);
      start = 1'b1;
      n_ltf = n;
      @(negedge clk);
      ls    = gen_letsgo;
      bz    = busy;
      start = 1'b0;
      n_ltf = 2'($urandom);
   endtask

   // Consumer: drives m_tready (0 always-ready, 1 toggling, 2 random),
   // holds it low while cyc < hold_until, records handshakes and stall stability.
   task automatic collect(input int max_hs, input int mode, input int hold_until, input int budget);
      int          n = 0;
      int          t = 0;
      bit          prev_stall = 1'b0;
      logic [31:0] prev_d = 32'h0;
      logic        prev_l = 1'b0;
      bit          done = 1'b0;
      got_data.delete();
      got_last.delete();
      first_valid_cyc = -1;
      last_hs_cyc     = -1;
      stall_err       = 0;
      idle_gaps       = 0;
      col_timeout     = 1'b0;
      while (!done) begin
         @(negedge clk);
         t++;
         case (mode)
            0:       m_tready = 1'b1;
            1:       m_tready = t[0];
            default: m_tready = 1'($urandom_range(0, 1));
         endcase
         if (cyc < hold_until) m_tready = 1'b0;
         if (prev_stall && (!m_tvalid || m_tdata !== prev_d || m_tlast !== prev_l)) stall_err++;
         if (m_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (!m_tvalid && first_valid_cyc >= 0) idle_gaps++;
         prev_stall = m_tvalid && !m_tready;
         prev_d     = m_tdata;
         prev_l     = m_tlast;
         if (m_tvalid && m_tready) begin
            got_data.push_back(m_tdata);
            got_last.push_back(m_tlast);
            n++;
            last_hs_cyc = cyc;
            if (m_tlast || n >= max_hs) done = 1'b1;
         end
         if (t >= budget && !done) begin
            col_timeout = 1'b1;
            done        = 1'b1;
         end
      end
   endtask

   task automatic test_reset();
      reset    = 1'b1;
      start    = 1'b0;
      n_ltf    = 2'd0;
      m_tready = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({gen_letsgo, gen_givemeoutput, m_tvalid, m_tlast, busy, err_timeout} !== 6'b0 || m_tdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_outputs: got ctl=%b data=%h, need ctl=000000 data=00000000",
                  {gen_letsgo, gen_givemeoutput, m_tvalid, m_tlast, busy, err_timeout}, m_tdata);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL idle_after_reset: got busy=%b tvalid=%b, need 0 0", busy, m_tvalid);
      end
   endtask

   task automatic test_single();
      logic ls, bz;
      for (int k = 0; k < 80; k++) samp[k] = {16'(k), 16'(-k)};
      gen_delay = $urandom_range(0, 3);
      do_start(2'd0, ls, bz);
      checks++;
      if (ls !== 1'b1 || bz !== 1'b1) begin
         errors++;
         $display("FAIL single_kick: got letsgo=%b busy=%b one cycle after start, need 1 1", ls, bz);
      end
      collect(1000, 0, 0, 400);
      checks++;
      if (col_timeout || got_data.size() != 80) begin
         errors++;
         $display("FAIL single_count: got %0d outputs timeout=%0d, need 80", got_data.size(), col_timeout);
      end
      for (int i = 0; i < got_data.size(); i++) begin
         checks++;
         if (got_data[i] !== samp[i % 80] || got_last[i] !== (i == 79)) begin
            errors++;
            $display("FAIL single_data[%0d]: got %h last=%0d, need %h last=%0d", i, got_data[i], got_last[i], samp[i % 80], (i == 79));
         end
      end
      checks++;
      if (first_valid_cyc != gen_start_cyc + 1) begin
         errors++;
         $display("FAIL single_first_valid: got cycle %0d, need %0d", first_valid_cyc, gen_start_cyc + 1);
      end
      checks++;
      if (last_hs_cyc - first_valid_cyc != 79 || idle_gaps != 0) begin
         errors++;
         $display("FAIL single_contiguous: got span %0d gaps %0d, need 79 0", last_hs_cyc - first_valid_cyc, idle_gaps);
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
         errors++;
         $display("FAIL single_busy_fall: got busy=%b tvalid=%b, need 0 0", busy, m_tvalid);
      end
   endtask

   task automatic test_two_sym();
      logic ls, bz;
      int   idx;
      fill_random();
      idx       = $urandom_range(0, 79);
      samp[idx] = {16'h8000, 16'h0001};
      samp[(idx + 7) % 80] = {16'h1234, 16'h8000};
      gen_delay = $urandom_range(0, 3);
      do_start(2'd1, ls, bz);
      collect(1000, 0, 0, 500);
      checks++;
      if (col_timeout || got_data.size() != 160) begin
         errors++;
         $display("FAIL two_count: got %0d outputs timeout=%0d, need 160", got_data.size(), col_timeout);
      end
      for (int i = 0; i < got_data.size(); i++) begin
         checks++;
         if (got_data[i] !== expect_word(i / 80, i % 80) || got_last[i] !== (i == 159)) begin
            errors++;
            $display("FAIL two_data[%0d]: got %h last=%0d, need %h last=%0d", i, got_data[i], got_last[i], expect_word(i / 80, i % 80), (i == 159));
         end
      end
      if (got_data.size() == 160) begin
         checks++;
         if (got_data[80 + idx] !== 32'h7FFF_FFFF) begin
            errors++;
            $display("FAIL two_saturate: got %h, need 7fffffff", got_data[80 + idx]);
         end
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL two_busy_fall: got busy=%b, need 0", busy);
      end
   endtask

   task automatic test_four_sym();
      logic ls, bz;
      for (int v = 0; v < 2; v++) begin
         fill_random();
         gen_delay = $urandom_range(0, 3);
         do_start((v == 0) ? 2'd2 : 2'd3, ls, bz);
         collect(1000, (v == 0) ? 1 : 2, 0, 2000);
         checks++;
         if (col_timeout || got_data.size() != 320) begin
            errors++;
            $display("FAIL four_count v%0d: got %0d outputs timeout=%0d, need 320", v, got_data.size(), col_timeout);
         end
         checks++;
         if (stall_err != 0) begin
            errors++;
            $display("FAIL four_stall_stable v%0d: got %0d unstable stalls, need 0", v, stall_err);
         end
         for (int i = 0; i < got_data.size(); i++) begin
            checks++;
            if (got_data[i] !== expect_word(i / 80, i % 80) || got_last[i] !== (i == 319)) begin
               errors++;
               $display("FAIL four_data v%0d[%0d]: got %h last=%0d, need %h last=%0d", v, i, got_data[i], got_last[i], expect_word(i / 80, i % 80), (i == 319));
            end
         end
         @(negedge clk);
         checks++;
         if (busy !== 1'b0) begin
            errors++;
            $display("FAIL four_busy_fall v%0d: got busy=%b, need 0", v, busy);
         end
      end
   endtask

   task automatic test_timeout();
      logic ls, bz;
      int   enter = -1;
      int   to_cyc = -1;
      bit   saw_valid = 1'b0;
      gen_enable = 1'b0;
      m_tready   = 1'b1;
      do_start(2'($urandom), ls, bz);
      for (int t = 0; t < 1200 && to_cyc < 0; t++) begin
         @(negedge clk);
         if (gen_givemeoutput && enter < 0) enter = cyc;
         if (m_tvalid) saw_valid = 1'b1;
         if (err_timeout) to_cyc = cyc;
      end
      checks++;
      if (to_cyc < 0 || enter < 0 || to_cyc - enter != 1023) begin
         errors++;
         $display("FAIL timeout_latency: got %0d cycles (pulse seen=%0d), need 1023", to_cyc - enter, (to_cyc >= 0));
      end
      @(negedge clk);
      if (m_tvalid) saw_valid = 1'b1;
      checks++;
      if (err_timeout !== 1'b0 || busy !== 1'b0 || gen_givemeoutput !== 1'b0) begin
         errors++;
         $display("FAIL timeout_after: got err=%b busy=%b give=%b, need 0 0 0", err_timeout, busy, gen_givemeoutput);
      end
      checks++;
      if (saw_valid) begin
         errors++;
         $display("FAIL timeout_no_valid: got tvalid during timeout, need none");
      end
      gen_enable = 1'b1;
      m_tready   = 1'b0;
   endtask

   task automatic test_backpressure();
      logic ls, bz;
      int   seen = -1;
      fill_random();
      m_tready  = 1'b0;
      gen_delay = $urandom_range(0, 3);
      do_start(2'd0, ls, bz);
      for (int t = 0; t < 20 && seen < 0; t++) begin
         @(negedge clk);
         if (m_tvalid) seen = cyc;
      end
      checks++;
      if (seen < 0) begin
         errors++;
         $display("FAIL bp_first_valid: got no tvalid within 20 cycles, need one");
      end
      collect(1000, 0, seen + 100, 400);
      checks++;
      if (col_timeout || got_data.size() != 80 || stall_err != 0) begin
         errors++;
         $display("FAIL bp_count: got %0d outputs timeout=%0d stall_err=%0d, need 80 0 0", got_data.size(), col_timeout, stall_err);
      end
      for (int i = 0; i < got_data.size(); i++) begin
         checks++;
         if (got_data[i] !== samp[i % 80] || got_last[i] !== (i == 79)) begin
            errors++;
            $display("FAIL bp_data[%0d]: got %h last=%0d, need %h last=%0d", i, got_data[i], got_last[i], samp[i % 80], (i == 79));
         end
      end
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      logic ls, bz;
      bit   any_last = 1'b0;
      fill_random();
      gen_delay = $urandom_range(0, 3);
      do_start(2'd2, ls, bz);
      collect(40, 0, 0, 200);
      for (int i = 0; i < got_last.size(); i++) if (got_last[i]) any_last = 1'b1;
      checks++;
      if (got_data.size() != 40 || any_last) begin
         errors++;
         $display("FAIL mid_partial: got %0d outputs last=%0d, need 40 0", got_data.size(), any_last);
      end
      for (int i = 0; i < got_data.size(); i++) begin
         checks++;
         if (got_data[i] !== samp[i]) begin
            errors++;
            $display("FAIL mid_data[%0d]: got %h, need %h", i, got_data[i], samp[i]);
         end
      end
      @(negedge clk);
      reset    = 1'b1;
      m_tready = 1'b0;
      @(negedge clk);
      checks++;
      if ({gen_letsgo, gen_givemeoutput, m_tvalid, m_tlast, busy, err_timeout} !== 6'b0 || m_tdata !== 32'h0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got ctl=%b data=%h, need 000000 00000000",
                  {gen_letsgo, gen_givemeoutput, m_tvalid, m_tlast, busy, err_timeout}, m_tdata);
      end
      reset = 1'b0;
      repeat (100) @(negedge clk);
      fill_random();
      do_start(2'd0, ls, bz);
      collect(1000, 0, 0, 400);
      checks++;
      if (col_timeout || got_data.size() != 80) begin
         errors++;
         $display("FAIL mid_rerun_count: got %0d outputs timeout=%0d, need 80", got_data.size(), col_timeout);
      end
      for (int i = 0; i < got_data.size(); i++) begin
         checks++;
         if (got_data[i] !== samp[i % 80] || got_last[i] !== (i == 79)) begin
            errors++;
            $display("FAIL mid_rerun_data[%0d]: got %h last=%0d, need %h last=%0d", i, got_data[i], got_last[i], samp[i % 80], (i == 79));
         end
      end
      @(negedge clk);
   endtask

   initial begin
      for (int k = 0; k < 80; k++) samp[k] = 32'h0;
      test_reset();
      test_single();
      test_two_sym();
      test_four_sym();
      test_timeout();
      test_backpressure();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
